sequenciador_exibicao: RTL and testbench

Controller that plays back the stored color sequence on the LEDs before the player repeats it. On `iniciar` it latches the round limit and walks the sequence memory from address 0 to `limite`. Each entry is lit for `ON_CYCLES` clocks and followed by `OFF_CYCLES` dark clocks. It then pulses `pronto`. It sits beside the game control unit: that unit starts it at the beginning of each round and waits for `pronto` before enabling player input.

---
 rtl/sequenciador_exibicao_if.sv | 25 ++
 rtl/sequenciador_exibicao.sv | 128 ++++++++++++
 tb/tb_sequenciador_exibicao.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/sequenciador_exibicao_if.sv
// Bus between the game control unit and the LED playback sequencer.
// The control unit drives requests and memory data; the sequencer drives address and LED outputs.
interface sequenciador_exibicao_if #(
    parameter int ADDR_W = 4
);
    logic              iniciar;
    logic              cancela;
    logic [ADDR_W-1:0] limite;
    logic [3:0]        dado;
    logic [ADDR_W-1:0] endereco;
    logic [3:0]        leds;
    logic              exibindo;
    logic              pronto;
    logic [3:0]        db_estado;

    modport master (
        output iniciar, cancela, limite, dado,
        input  endereco, leds, exibindo, pronto, db_estado
    );

    modport slave (
        input  iniciar, cancela, limite, dado,
        output endereco, leds, exibindo, pronto, db_estado
    );
endinterface

// File: rtl/sequenciador_exibicao.sv
// Plays the stored color sequence from address 0 up to the latched limit on the LEDs,
// each entry lit for ON_CYCLES and dark for OFF_CYCLES, then pulses pronto.
//
// state   | meaning
// OCIOSO  | idle, waiting for iniciar
// CARREGA | one-cycle memory read of the current address
// ACENDE  | entry shown on leds for ON_CYCLES
// APAGA   | dark gap for OFF_CYCLES
// PROXIMO | decide: finish or advance address
// FIM     | one-cycle pronto pulse
module sequenciador_exibicao #(
    parameter int ADDR_W     = 4,
    parameter int ON_CYCLES  = 1000,
    parameter int OFF_CYCLES = 500
) (
    input logic                 clock,
    input logic                 reset,
    sequenciador_exibicao_if.slave bus
);
    localparam int MAX_C = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int TW    = (MAX_C > 1) ? $clog2(MAX_C) : 1;
    localparam logic [TW-1:0] ON_TC  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] OFF_TC = TW'(OFF_CYCLES - 1);

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        CARREGA = 3'd1,
        ACENDE  = 3'd2,
        APAGA   = 3'd3,
        PROXIMO = 3'd4,
        FIM     = 3'd5
    } estado_t;

    estado_t           estado_q, estado_d;
    logic [ADDR_W-1:0] endereco_q, endereco_d;
    logic [ADDR_W-1:0] lim_q, lim_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              exibindo_q, exibindo_d;
    logic              pronto_q, pronto_d;

    always_comb begin
        estado_d   = estado_q;
        endereco_d = endereco_q;
        lim_d      = lim_q;
        timer_d    = timer_q;

        // cancela outranks every normal transition; in OCIOSO it simply blocks iniciar
        if (bus.cancela && (estado_q != OCIOSO)) begin
            estado_d = OCIOSO;
            timer_d  = '0;
        end else begin
            case (estado_q)
                OCIOSO: begin
                    if (bus.iniciar && !bus.cancela) begin
                        estado_d   = CARREGA;
                        endereco_d = '0;
                        lim_d      = bus.limite;
                        timer_d    = '0;
                    end
                end
                CARREGA: begin
                    estado_d = ACENDE;
                    timer_d  = '0;
                end
                ACENDE: begin
                    if (timer_q == ON_TC) begin
                        estado_d = APAGA;
                        timer_d  = '0;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                APAGA: begin
                    if (timer_q == OFF_TC) begin
                        estado_d = PROXIMO;
                        timer_d  = '0;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                PROXIMO: begin
                    // compare before incrementing so the full-depth limit never wraps
                    if (endereco_q == lim_q) begin
                        estado_d = FIM;
                    end else begin
                        endereco_d = endereco_q + ADDR_W'(1);
                        estado_d   = CARREGA;
                    end
                end
                FIM: begin
                    estado_d = OCIOSO;
                end
                default: begin
                    estado_d = OCIOSO;
                    timer_d  = '0;
                end
            endcase
        end

        exibindo_d = (estado_d == CARREGA) || (estado_d == ACENDE) ||
                     (estado_d == APAGA)   || (estado_d == PROXIMO);
        pronto_d   = (estado_d == FIM);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado_q   <= OCIOSO;
            endereco_q <= '0;
            lim_q      <= '0;
            timer_q    <= '0;
            exibindo_q <= 1'b0;
            pronto_q   <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            endereco_q <= endereco_d;
            lim_q      <= lim_d;
            timer_q    <= timer_d;
            exibindo_q <= exibindo_d;
            pronto_q   <= pronto_d;
        end
    end

    assign bus.endereco  = endereco_q;
    assign bus.exibindo  = exibindo_q;
    assign bus.pronto    = pronto_q;
    assign bus.db_estado = {1'b0, estado_q};
    assign bus.leds      = (estado_q == ACENDE) ? bus.dado : 4'd0;
endmodule

// File: tb/tb_sequenciador_exibicao.sv
// Randomized self-checking bench for sequenciador_exibicao against a cycle-position model.
module tb_sequenciador_exibicao;
    localparam int AW  = 2;
    localparam int ON  = 3;
    localparam int OFF = 2;
    localparam int P   = ON + OFF + 2;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    sequenciador_exibicao_if #(.ADDR_W(AW)) bus ();

    sequenciador_exibicao #(
        .ADDR_W(AW),
        .ON_CYCLES(ON),
        .OFF_CYCLES(OFF)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    logic [3:0] mem [4];
    assign bus.dado = mem[bus.endereco];

    logic [11:0] obs;
    assign obs = {bus.db_estado, bus.endereco, bus.leds, bus.exibindo, bus.pronto};

    int vectors    = 0;
    int miscompares = 0;

    // Expected outputs in cycle k after a start with limit lim: each entry is a P-cycle window
    // (load, ON lit, OFF dark, advance), FIM lands right after the last window.
    function automatic logic [11:0] model(input int k, input int lim);
        int total, e, ph, code;
        logic [3:0] l;
        total = 1 + (lim + 1) * P;
        if (k >= total) begin
            e    = lim;
            code = (k == total) ? 5 : 0;
        end else begin
            e  = (k - 1) / P;
            ph = (k - 1) % P;
            if (ph == 0)             code = 1;
            else if (ph <= ON)       code = 2;
            else if (ph <= ON + OFF) code = 3;
            else                     code = 4;
        end
        l = (code == 2) ? mem[e] : 4'd0;
        return {4'(code), AW'(e), l, (code >= 1 && code <= 4), (code == 5)};
    endfunction

    task automatic play(input int lim, input int cancel_at, input bit noise, input string tag);
        int          total;
        int          last_e;
        logic [11:0] exp;
        total  = 1 + (lim + 1) * P;
        last_e = 0;
        @(negedge clock);
        bus.limite  = AW'(lim);
        bus.iniciar = 1'b1;
        for (int k = 1; k <= total + 1; k++) begin
            @(negedge clock);
            if (cancel_at > 0 && k == cancel_at + 1)
                exp = {4'd0, AW'(last_e), 4'd0, 1'b0, 1'b0};
            else
                exp = model(k, lim);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL %s cycle %0d: observed %h required %h (estado,endereco,leds,exibindo,pronto)",
                         tag, k, obs, exp);
            end
            if (cancel_at > 0 && k == cancel_at + 1) begin
                bus.cancela = 1'b0;
                bus.iniciar = 1'b0;
                break;
            end
            last_e = int'(exp[7:6]);
            if (noise && k < total) begin
                bus.iniciar = 1'($urandom_range(0, 1));
                bus.limite  = AW'($urandom);
            end else begin
                bus.iniciar = 1'b0;
            end
            if (k == cancel_at) bus.cancela = 1'b1;
        end
        bus.iniciar = 1'b0;
        bus.cancela = 1'b0;
    endtask

    task automatic test_reset;
        bus.iniciar = 1'b1;
        reset = 1'b0;
        repeat (2) begin
            @(negedge clock);
            vectors++;
            if (obs !== 12'h000) begin
                miscompares++;
                $display("FAIL reset_hold: observed %h required 000", obs);
            end
        end
        bus.iniciar = 1'b0;
        reset = 1'b1;
        // reset in the middle of a playback
        mem[0] = 4'h3; mem[1] = 4'h5; mem[2] = 4'h9; mem[3] = 4'hC;
        @(negedge clock);
        bus.limite  = AW'(3);
        bus.iniciar = 1'b1;
        @(negedge clock);
        bus.iniciar = 1'b0;
        repeat (9) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        vectors++;
        if (obs !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_mid: observed %h required 000", obs);
        end
        reset = 1'b1;
    endtask

    task automatic test_basic;
        mem[0] = 4'b0001; mem[1] = 4'b1000; mem[2] = 4'b0100; mem[3] = 4'($urandom);
        play(1, 0, 1'b0, "basic");
    endtask

    task automatic test_single;
        mem[0] = 4'hA; mem[1] = 4'h6;
        play(0, 0, 1'b0, "single");
    endtask

    task automatic test_full_depth;
        for (int i = 0; i < 4; i++) mem[i] = 4'($urandom_range(1, 15));
        play(3, 0, 1'b0, "full_depth");
    endtask

    task automatic test_cancel;
        for (int i = 0; i < 4; i++) mem[i] = 4'($urandom_range(1, 15));
        play(3, P + 3, 1'b0, "cancel");
        repeat (3) begin
            @(negedge clock);
            vectors++;
            if (bus.pronto !== 1'b0 || bus.db_estado !== 4'd0) begin
                miscompares++;
                $display("FAIL cancel_idle: observed pronto=%b estado=%0d required pronto=0 estado=0",
                         bus.pronto, bus.db_estado);
            end
        end
        play(1, 0, 1'b0, "cancel_restart");
    endtask

    task automatic test_cancel_over_start;
        @(negedge clock);
        bus.iniciar = 1'b1;
        bus.cancela = 1'b1;
        @(negedge clock);
        bus.iniciar = 1'b0;
        bus.cancela = 1'b0;
        vectors++;
        if (bus.db_estado !== 4'd0 || bus.exibindo !== 1'b0) begin
            miscompares++;
            $display("FAIL cancel_priority: observed estado=%0d exibindo=%b required estado=0 exibindo=0",
                     bus.db_estado, bus.exibindo);
        end
    endtask

    task automatic test_ignored;
        for (int i = 0; i < 4; i++) mem[i] = 4'($urandom_range(1, 15));
        play(2, 0, 1'b1, "ignored");
    endtask

    task automatic test_random;
        repeat (8) begin
            for (int i = 0; i < 4; i++) mem[i] = 4'($urandom);
            play(int'($urandom_range(0, 3)), 0, 1'($urandom_range(0, 1)), "random");
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 4; i++) mem[i] = 4'($urandom_range(1, 15));
        play(1, 0, 1'b0, "back_to_back_a");
        play(2, 0, 1'b0, "back_to_back_b");
    endtask

    initial begin
        bus.iniciar = 1'b0;
        bus.cancela = 1'b0;
        bus.limite  = '0;
        for (int i = 0; i < 4; i++) mem[i] = 4'd0;
        test_reset();
        test_basic();
        test_single();
        test_full_depth();
        test_cancel();
        test_cancel_over_start();
        test_ignored();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
